// File: rtl/config_regfile.sv
// UART-driven configuration register file: framed write/read/commit bytes feed shadow
// registers that transfer atomically to cfg_q on commit (deferred while stall_commit is high).
//
// state | meaning
// IDLE  | waiting for a header byte; COMMIT and READ headers are decoded here
// WDATA | collecting write data bytes LSB-first, idle timeout armed
// RDATA | emitting read-back bytes LSB-first under tx_ready handshake
module config_regfile #(
   parameter int                           NUM_REGS    = 4,
   parameter int                           DATA_W      = 4,
   parameter logic [NUM_REGS*DATA_W-1:0]   RESET_VALS  = {4'h1, 4'hF, 4'h0, 4'h0},
   parameter logic [NUM_REGS-1:0]          WP_MASK     = '0,
   parameter int                           TIMEOUT_CYC = 1000000
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [7:0]                   rx_data,
   input  logic                         rx_valid,
   input  logic                         stall_commit,
   output logic [7:0]                   tx_data,
   output logic                         tx_valid,
   input  logic                         tx_ready,
   output logic [NUM_REGS*DATA_W-1:0]   cfg_q,
   output logic                         commit_pulse,
   output logic                         cmd_err,
   output logic                         busy
);
   localparam int NB = (DATA_W + 7) / 8;
   localparam int SW = NB * 8;
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [15:0] WP_EXT = 16'(WP_MASK);

   typedef enum logic [1:0] {IDLE = 2'd0, WDATA = 2'd1, RDATA = 2'd2} state_t;

   state_t                      state;
   logic [3:0]                  idx_q;
   logic [2:0]                  cnt;
   logic [SW-1:0]               staging;
   logic [TW-1:0]               tmo;
   logic                        pending;
   logic [DATA_W-1:0]           shadow      [NUM_REGS];
   logic [DATA_W-1:0]           shadow_next [NUM_REGS];
   logic [NUM_REGS*DATA_W-1:0]  cfg_next;
   logic [SW-1:0]               stage_full;
   logic [SW-1:0]               rd_vec;
   logic [7:0]                  rd_hdr;
   logic [7:0]                  rd_next;
   logic                        idx_ok;
   logic                        hdr_idx_ok;
   logic                        last_byte;
   logic                        wr_ok;
   logic                        commit_hdr;
   logic                        commit_now;

   assign idx_ok     = ({1'b0, idx_q} < 5'(NUM_REGS));
   assign hdr_idx_ok = ({1'b0, rx_data[3:0]} < 5'(NUM_REGS));
   assign last_byte  = (state == WDATA) && rx_valid && (cnt == 3'(NB - 1));
   assign wr_ok      = last_byte && idx_ok && !WP_EXT[idx_q];
   assign commit_hdr = (state == IDLE) && rx_valid && (rx_data[7:4] == 4'h3);
   assign commit_now = (pending || commit_hdr) && !stall_commit;
   assign busy       = (state != IDLE) || pending;

   always_comb begin
      rd_vec     = '0;
      rd_hdr     = '0;
      rd_next    = '0;
      stage_full = staging;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (idx_q == 4'(i))        rd_vec = SW'(shadow[i]);
         if (rx_data[3:0] == 4'(i)) rd_hdr = 8'(shadow[i]);
      end
      for (int b = 0; b < NB; b++) begin
         if (cnt + 3'd1 == 3'(b)) rd_next = rd_vec[b*8 +: 8];
         if (cnt == 3'(b))        stage_full[b*8 +: 8] = rx_data;
      end
   end

   // the commit snapshot is taken from shadow_next so a same-cycle write is included
   always_comb begin
      cfg_next = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         shadow_next[i] = shadow[i];
         if (wr_ok && idx_q == 4'(i)) shadow_next[i] = stage_full[DATA_W-1:0];
         cfg_next[i*DATA_W +: DATA_W] = shadow_next[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         idx_q        <= '0;
         cnt          <= '0;
         staging      <= '0;
         tmo          <= '0;
         pending      <= 1'b0;
         commit_pulse <= 1'b0;
         cmd_err      <= 1'b0;
         tx_data      <= '0;
         tx_valid     <= 1'b0;
         cfg_q        <= RESET_VALS;
         for (int i = 0; i < NUM_REGS; i++) shadow[i] <= RESET_VALS[i*DATA_W +: DATA_W];
      end else begin
         commit_pulse <= 1'b0;
         cmd_err      <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) shadow[i] <= shadow_next[i];
         if (commit_now) begin
            cfg_q        <= cfg_next;
            commit_pulse <= 1'b1;
            pending      <= 1'b0;
         end else if (commit_hdr) begin
            pending <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (rx_valid) begin
                  case (rx_data[7:4])
                     4'h1: begin
                        state   <= WDATA;
                        idx_q   <= rx_data[3:0];
                        cnt     <= '0;
                        staging <= '0;
                        tmo     <= TW'(TIMEOUT_CYC - 1);
                     end
                     4'h2: begin
                        if (hdr_idx_ok) begin
                           state    <= RDATA;
                           idx_q    <= rx_data[3:0];
                           cnt      <= '0;
                           tx_valid <= 1'b1;
                           tx_data  <= rd_hdr;
                        end else begin
                           cmd_err <= 1'b1;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            WDATA: begin
               if (rx_valid) begin
                  staging <= stage_full;
                  tmo     <= TW'(TIMEOUT_CYC - 1);
                  if (last_byte) begin
                     state <= IDLE;
                     if (!wr_ok) cmd_err <= 1'b1;
                  end else begin
                     cnt <= cnt + 3'd1;
                  end
               end else if (tmo == '0) begin
                  state   <= IDLE;
                  cmd_err <= 1'b1;
               end else begin
                  tmo <= tmo - TW'(1);
               end
            end
            RDATA: begin
               if (rx_valid) cmd_err <= 1'b1;
               if (tx_ready) begin
                  if (cnt == 3'(NB - 1)) begin
                     tx_valid <= 1'b0;
                     state    <= IDLE;
                  end else begin
                     cnt     <= cnt + 3'd1;
                     tx_data <= rd_next;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_config_regfile.sv
// Randomised bench for config_regfile against a transaction-level model of shadow/active registers.
module tb_config_regfile;
   localparam int NR = 4;
   localparam int DW = 12;
   localparam int NB = 2;
   localparam int TO = 16;
   localparam logic [NR*DW-1:0] RV = {12'hABC, 12'h0F1, 12'h123, 12'h456};
   localparam logic [NR-1:0]    WP = 4'b1000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic rx_valid = 1'b0;
   logic stall_commit = 1'b0;
   logic tx_ready = 1'b0;
   logic [7:0] tx_data;
   logic tx_valid;
   logic [NR*DW-1:0] cfg_q;
   logic commit_pulse, cmd_err, busy;

   always #5 clk = ~clk;

   config_regfile #(.NUM_REGS(NR), .DATA_W(DW), .RESET_VALS(RV), .WP_MASK(WP), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .stall_commit(stall_commit),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .cfg_q(cfg_q),
      .commit_pulse(commit_pulse), .cmd_err(cmd_err), .busy(busy));

   int n_checks = 0, n_err = 0;
   int err_seen = 0, err_exp = 0, pulse_seen = 0, pulse_exp = 0;
   logic [DW-1:0] shadow_m [NR];
   logic [DW-1:0] cfg_m    [NR];

   always @(posedge clk) begin
      if (cmd_err) err_seen++;
      if (commit_pulse) pulse_seen++;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [NR*DW-1:0] pack_cfg();
      logic [NR*DW-1:0] r;
      for (int i = 0; i < NR; i++) r[i*DW +: DW] = cfg_m[i];
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NR; i++) begin
         shadow_m[i] = RV[i*DW +: DW];
         cfg_m[i]    = RV[i*DW +: DW];
      end
   endtask

   task automatic model_commit();
      for (int i = 0; i < NR; i++) cfg_m[i] = shadow_m[i];
      pulse_exp++;
   endtask

   // called at a negedge; returns at the negedge after the byte was clocked in
   task automatic send(input logic [7:0] b);
      rx_data = b; rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0; rx_data = 8'h00;
   endtask

   task automatic do_write(input int idx, input logic [DW-1:0] d, input int gap);
      logic bad;
      bad = 1'b1;
      if (idx < NR) bad = WP[idx];
      send(8'h10 | 8'(idx));
      repeat (gap) @(negedge clk);
      send(d[7:0]);
      repeat (gap) @(negedge clk);
      send({4'($urandom), d[11:8]});
      check("wr_err", cmd_err, bad);
      if (bad) err_exp++;
      else shadow_m[idx] = d;
   endtask

   task automatic do_commit();
      send(8'h30);
      model_commit();
      check("commit_pulse", commit_pulse, 1);
      check("commit_cfg", cfg_q, pack_cfg());
   endtask

   task automatic do_read(input int idx, input bit inject);
      logic [15:0] padded;
      int w;
      send(8'h20 | 8'(idx));
      if (idx >= NR) begin
         check("rd_bad_err", cmd_err, 1);
         check("rd_bad_txv", tx_valid, 0);
         err_exp++;
         return;
      end
      padded = 16'(shadow_m[idx]);
      for (int b = 0; b < NB; b++) begin
         w = $urandom_range(0, 4);
         if (inject && b == 0 && w == 0) w = 1;
         for (int k = 0; k < w; k++) begin
            check("rd_hold_valid", tx_valid, 1);
            check("rd_hold_data", tx_data, padded[b*8 +: 8]);
            if (inject && b == 0 && k == 0) begin
               rx_data = 8'h12; rx_valid = 1'b1;
               err_exp++;
            end
            @(negedge clk);
            rx_valid = 1'b0;
            if (inject && b == 0 && k == 0) check("rd_rx_err", cmd_err, 1);
         end
         check("rd_data", tx_data, padded[b*8 +: 8]);
         tx_ready = 1'b1;
         @(negedge clk);
         tx_ready = 1'b0;
      end
      check("rd_done_txv", tx_valid, 0);
      check("rd_done_busy", busy, 0);
   endtask

   task automatic check_counts();
      repeat (2) @(negedge clk);
      check("err_count", err_seen, err_exp);
      check("pulse_count", pulse_seen, pulse_exp);
      check("cfg_idle", cfg_q, pack_cfg());
   endtask

   initial begin
      int i;
      model_reset();
      repeat (3) @(negedge clk);
      check("rst_cfg", cfg_q, RV);
      check("rst_busy", busy, 0);
      check("rst_strobes", {tx_valid, commit_pulse, cmd_err}, 0);
      check("rst_txdata", tx_data, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_cfg", cfg_q, RV);
      check("post_rst_busy", busy, 0);

      do_write(2, 12'h007, 0);
      check("wr_busy", busy, 0);
      do_commit();

      // stalled commit with a repeated COMMIT and a write landing while pending
      stall_commit = 1'b1;
      do_write(0, 12'h005, 1);
      send(8'h30);
      check("stall_no_pulse", commit_pulse, 0);
      send(8'h30);
      repeat (50) @(negedge clk);
      check("stall_cfg_held", cfg_q, pack_cfg());
      check("stall_busy", busy, 1);
      do_write(1, 12'h3C5, 2);
      stall_commit = 1'b0;
      @(negedge clk);
      model_commit();
      check("unstall_pulse", commit_pulse, 1);
      check("unstall_cfg", cfg_q, pack_cfg());
      @(negedge clk);
      check("collapse_single", commit_pulse, 0);
      check("unstall_busy", busy, 0);

      // final write byte and commit release in the same cycle
      stall_commit = 1'b1;
      send(8'h30);
      send(8'h12);
      send(8'h44);
      rx_data = 8'hFE; rx_valid = 1'b1; stall_commit = 1'b0;
      @(negedge clk);
      rx_valid = 1'b0;
      shadow_m[2] = 12'hE44;
      model_commit();
      check("same_cyc_pulse", commit_pulse, 1);
      check("same_cyc_cfg", cfg_q, pack_cfg());

      do_write(9, 12'h111, 0);
      do_write(3, 12'h222, 1);
      do_commit();

      send(8'h55);
      check("other_op_err", cmd_err, 0);
      check("other_op_busy", busy, 0);

      send(8'h11);
      send(8'hAB);
      for (i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (cmd_err) break;
      end
      check("timeout_cycle", i, TO);
      err_exp++;
      @(negedge clk);
      check("timeout_idle", busy, 0);
      do_read(1, 0);

      do_read(3, 1);
      do_read(6, 0);
      check_counts();

      // reset in the middle of a write discards it
      send(8'h12);
      send(8'h77);
      rst_n = 1'b0;
      @(negedge clk);
      model_reset();
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst_cfg", cfg_q, RV);
      check("midrst_busy", busy, 0);
      do_read(2, 0);

      for (int it = 0; it < 150; it++) begin
         case ($urandom_range(0, 3))
            0: do_write($urandom_range(0, 5), 12'($urandom), $urandom_range(0, 4));
            1: do_read($urandom_range(0, 4), 1'($urandom));
            2: do_commit();
            default: begin
               stall_commit = 1'b1;
               send(8'h30);
               check("rnd_stall_busy", busy, 1);
               repeat ($urandom_range(1, 10)) @(negedge clk);
               if ($urandom_range(0, 1) == 1) do_write($urandom_range(0, 5), 12'($urandom), 0);
               check("rnd_stall_cfg", cfg_q, pack_cfg());
               stall_commit = 1'b0;
               @(negedge clk);
               model_commit();
               check("rnd_unstall_pulse", commit_pulse, 1);
               check("rnd_unstall_cfg", cfg_q, pack_cfg());
            end
         endcase
         if (it % 10 == 9) check_counts();
      end
      check_counts();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
